switch_conditioner: RTL
=======================

# switch_conditioner

Input-conditioning stage between the raw board switches and the digit-select/display logic of the top level. It synchronizes each switch bit into the `clk_2` domain and debounces it with a per-bit counter. It presents a clean registered switch word to the downstream consumer, plus one-cycle rise/fall pulses per bit. The display FSM reads `sw_stable` in place of raw `SWI`, so glitches and metastable samples never reach its `case` selection or its reset bit.

## Interface

Parameters:
- `NBITS` — 8 — switch word width.
- `DEBOUNCE_CYCLES` — 4 — consecutive cycles a synchronized bit must differ from its stable value before the stable value flips; legal range 1..255.

Ports:
- `clk_2` — input — 1 — single system clock; all state on its rising edge.
- `reset` — input — 1 — asynchronous, active-low reset; asserting it (0) clears all state immediately, independent of `clk_2`.
- `SWI` — input — NBITS — raw asynchronous switch levels.
- `sw_stable` — output — NBITS — debounced, registered switch word.
- `sw_rise` — output — NBITS — one-cycle pulse per bit on a stable 0→1 transition.
- `sw_fall` — output — NBITS — one-cycle pulse per bit on a stable 1→0 transition.
- `sw_changed` — output — 1 — OR of all `sw_rise | sw_fall` bits, registered with them.

## Operation

- Per bit: 2-flop synchronizer `sync1 → sync2`, then a debounce FSM with a counter of width `$clog2(DEBOUNCE_CYCLES+1)`.
- FSM states:
  - STABLE: `sync2 == q`; counter held at 0.
  - COUNTING: `sync2 != q`.
- Transitions on each edge:
  - STABLE, `sync2 != q`: go to COUNTING, counter ← 1. If `DEBOUNCE_CYCLES == 1`, instead q ← sync2 directly and stay in STABLE.
  - COUNTING, `sync2 == q` (bounce back): go to STABLE, counter ← 0, q unchanged, no pulse.
  - COUNTING, `sync2 != q`, counter == `DEBOUNCE_CYCLES-1`: q ← sync2, counter ← 0, go to STABLE, pulse the matching rise/fall bit.
  - COUNTING, otherwise: counter ← counter+1.
- `sw_rise[i]` and `sw_fall[i]` are mutually exclusive and never high in consecutive cycles for the same bit. They are registered: high exactly in the cycle in which the new `q` is visible.
- Bits are fully independent; simultaneous transitions on several bits produce simultaneous pulses and one `sw_changed` pulse.
- Counter never wraps: it saturates conceptually at `DEBOUNCE_CYCLES-1`, where the flip occurs.

## Timing

- Reset values: `sync1`, `sync2`, `q`, counters, `sw_stable`, `sw_rise`, `sw_fall` and `sw_changed` are all 0. All FSMs are in STABLE.
- Latency:
  - Clean level change on `SWI[i]` captured at edge k → `sw_stable[i]` changes after edge k+1+DEBOUNCE_CYCLES.
  - Default parameter: 5 edges.
  - The matching pulse is high for exactly the following cycle.
- Bounce: any return of `sync2` to `q` before the terminal count restarts the count from 0 on the next difference.
- Reset asserted mid-count: state is discarded and no pulse is emitted.
- Reset release with a switch held at 1: treated as a normal 0→1 transition, so a rise pulse appears DEBOUNCE_CYCLES+2 edges after release.

## Configuration

- `SWITCH_CONDITIONER_EDGE_EN` defined: `sw_rise`, `sw_fall` and `sw_changed` are generated as described above.
- Not defined: the three ports remain in the port list, tied to constant 0. Edge registers are not synthesized. `sw_stable` behaviour is unchanged.

## Structure

- Shared package `switch_conditioner_pkg`:
  - Debounce state enum `deb_state_t` {DEB_STABLE, DEB_COUNTING}.
  - Default constants `SWC_NBITS = 8` and `SWC_DEBOUNCE_CYCLES = 4`.
- Sub-module `debounce_bit`:
  - Contains the synchronizer, the counter/FSM, and the rise/fall pulse for one bit.
  - Instantiated NBITS times in a generate loop.
  - The top-level `switch_conditioner` only concatenates outputs and forms `sw_changed`.

## Test plan

- Reset: drive `reset`=0 with `SWI`=8'hFF, asynchronously mid-cycle → all outputs 0 immediately, independent of `clk_2`, and they stay 0 while reset is held.
- Clean edge: with reset released, `SWI` 8'h00→8'h04 before edge k → `sw_stable`=8'h04 after edge k+5. `sw_rise`=8'h04 and `sw_changed`=1 for exactly one cycle.
- Bounce: `SWI[2]` toggles 1,0,1,0 on successive edges, then holds 0 → no change during toggling. `sw_fall[2]` pulses once, 5 edges after the final 0 is captured.
- Simultaneous: `SWI` 8'h0F→8'hF0 in one step → after 5 edges `sw_stable`=8'hF0, `sw_rise`=8'hF0, `sw_fall`=8'h0F, and a single `sw_changed` pulse.
- Reset mid-count: `SWI[3]`=1 for 3 edges, then `reset`=0 → no pulse and `sw_stable`=0. After release, `sw_rise[3]` fires 6 edges later.
- Macro off: compile without `SWITCH_CONDITIONER_EDGE_EN` and repeat the clean-edge case → `sw_stable` timing is identical; `sw_rise`, `sw_fall` and `sw_changed` stay 0 throughout.

Source files
------------

// File: rtl/switch_conditioner_pkg.sv
`default_nettype none
// ============================================================================
// Module   : switch_conditioner_pkg
// Purpose  : Shared types and default constants for the switch conditioner
//            and its per-bit debounce cell.
// Contents : deb_state_t   - per-bit debounce state
//            SWC_NBITS     - default switch word width
//            SWC_DEBOUNCE_CYCLES - default debounce length in clk_2 cycles
//            cnt_width()   - width of a counter that must hold 0..cycles
// Macro    : none (SWITCH_CONDITIONER_EDGE_EN is consumed by the modules)
// Revision : 1.0 - initial release
// ============================================================================
package switch_conditioner_pkg;

    localparam int SWC_NBITS           = 8;
    localparam int SWC_DEBOUNCE_CYCLES = 4;

    typedef enum logic [0:0] {
        DEB_STABLE   = 1'b0,
        DEB_COUNTING = 1'b1
    } deb_state_t;

    // Counter width needed to represent every value from 0 to cycles.
    function automatic int cnt_width(input int cycles);
        return $clog2(cycles + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/debounce_bit.sv
`default_nettype none
// ============================================================================
// Module   : debounce_bit
// Purpose  : One switch bit: two-flop synchronizer into clk_2, debounce
//            FSM with a per-bit counter, and registered rise/fall pulses.
// Ports    : clk_2        in   system clock, rising edge
//            reset        in   asynchronous active-low reset
//            i_sw         in   raw asynchronous switch level
//            o_q          out  debounced registered level
//            o_rise       out  one-cycle pulse, aligned with q going 0->1
//            o_fall       out  one-cycle pulse, aligned with q going 1->0
//            o_flip_next  out  combinational: q flips on the coming edge
// Macro    : SWITCH_CONDITIONER_EDGE_EN - when undefined the pulse
//            registers are not built and o_rise/o_fall are tied to 0.
// Revision : 1.0 - initial release
// ============================================================================
module debounce_bit
    import switch_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = SWC_DEBOUNCE_CYCLES
) (
    input  logic clk_2,
    input  logic reset,
    input  logic i_sw,
    output logic o_q,
    output logic o_rise,
    output logic o_fall,
    output logic o_flip_next
);

    localparam int                 c_CNT_W = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [c_CNT_W-1:0] c_TERM  = c_CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_ONE   = c_CNT_W'(1);

    logic               r_sync1;
    logic               r_sync2;
    logic               r_q;
    logic [c_CNT_W-1:0] r_cnt;
    deb_state_t         r_state;

    deb_state_t         w_state_next;
    logic [c_CNT_W-1:0] w_cnt_next;
    logic               w_q_next;
    logic               w_flip;

    // ------------------------------------------------------------------
    // State register, synchronizer and debounced level
    // ------------------------------------------------------------------
    always_ff @(posedge clk_2 or negedge reset) begin
        if (!reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_q     <= 1'b0;
            r_cnt   <= '0;
            r_state <= DEB_STABLE;
        end else begin
            r_sync1 <= i_sw;
            r_sync2 <= r_sync1;
            r_q     <= w_q_next;
            r_cnt   <= w_cnt_next;
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic. The counter counts edges on which the synchronized
    // level has disagreed with q; any agreement drops back to STABLE so
    // the next disagreement starts over from 1.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_q_next     = r_q;
        w_flip       = 1'b0;

        case (r_state)
            DEB_STABLE: begin
                w_cnt_next = '0;
                if (r_sync2 != r_q) begin
                    if (DEBOUNCE_CYCLES == 1) begin
                        // Single-cycle debounce: accept the new level at once.
                        w_q_next = r_sync2;
                        w_flip   = 1'b1;
                    end else begin
                        w_state_next = DEB_COUNTING;
                        w_cnt_next   = c_ONE;
                    end
                end
            end

            DEB_COUNTING: begin
                if (r_sync2 == r_q) begin
                    w_state_next = DEB_STABLE;
                    w_cnt_next   = '0;
                end else if (r_cnt == c_TERM) begin
                    w_state_next = DEB_STABLE;
                    w_cnt_next   = '0;
                    w_q_next     = r_sync2;
                    w_flip       = 1'b1;
                end else begin
                    w_cnt_next = r_cnt + c_ONE;
                end
            end

            default: begin
                w_state_next = DEB_STABLE;
                w_cnt_next   = '0;
            end
        endcase
    end

    assign o_q         = r_q;
    assign o_flip_next = w_flip;

    // ------------------------------------------------------------------
    // Edge pulses, registered alongside q so they line up with the new level
    // ------------------------------------------------------------------
`ifdef SWITCH_CONDITIONER_EDGE_EN
    logic r_rise;
    logic r_fall;

    always_ff @(posedge clk_2 or negedge reset) begin
        if (!reset) begin
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            r_rise <= w_flip & w_q_next;
            r_fall <= w_flip & ~w_q_next;
        end
    end

    assign o_rise = r_rise;
    assign o_fall = r_fall;
`else
    assign o_rise = 1'b0;
    assign o_fall = 1'b0;
`endif

endmodule
`default_nettype wire

// File: rtl/switch_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : switch_conditioner
// Purpose  : Conditions the raw board switch word for the display logic:
//            synchronizes and debounces each bit independently and offers
//            per-bit rise/fall pulses plus a combined change pulse.
// Ports    : clk_2       in   system clock, rising edge
//            reset       in   asynchronous active-low reset
//            SWI         in   [NBITS] raw asynchronous switch levels
//            sw_stable   out  [NBITS] debounced registered switch word
//            sw_rise     out  [NBITS] one-cycle 0->1 pulses
//            sw_fall     out  [NBITS] one-cycle 1->0 pulses
//            sw_changed  out  OR of all rise/fall pulses, same cycle
// Macro    : SWITCH_CONDITIONER_EDGE_EN - when undefined sw_rise, sw_fall
//            and sw_changed are tied to 0; sw_stable is unaffected.
// Revision : 1.0 - initial release
// ============================================================================
module switch_conditioner
    import switch_conditioner_pkg::*;
#(
    parameter int NBITS           = SWC_NBITS,
    parameter int DEBOUNCE_CYCLES = SWC_DEBOUNCE_CYCLES
) (
    input  logic             clk_2,
    input  logic             reset,
    input  logic [NBITS-1:0] SWI,
    output logic [NBITS-1:0] sw_stable,
    output logic [NBITS-1:0] sw_rise,
    output logic [NBITS-1:0] sw_fall,
    output logic             sw_changed
);

    logic [NBITS-1:0] w_flip_next;

    generate
        for (genvar gi = 0; gi < NBITS; gi++) begin : g_bit
            debounce_bit #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
            ) u_debounce_bit (
                .clk_2       (clk_2),
                .reset       (reset),
                .i_sw        (SWI[gi]),
                .o_q         (sw_stable[gi]),
                .o_rise      (sw_rise[gi]),
                .o_fall      (sw_fall[gi]),
                .o_flip_next (w_flip_next[gi])
            );
        end
    endgenerate

`ifdef SWITCH_CONDITIONER_EDGE_EN
    // Registered from the per-bit flip indications so it asserts in the
    // same cycle as the rise/fall pulses it summarizes.
    logic r_changed;

    always_ff @(posedge clk_2 or negedge reset) begin
        if (!reset) begin
            r_changed <= 1'b0;
        end else begin
            r_changed <= |w_flip_next;
        end
    end

    assign sw_changed = r_changed;
`else
    logic w_unused_flip;
    assign w_unused_flip = ^w_flip_next;
    assign sw_changed    = 1'b0;
`endif

endmodule
`default_nettype wire
